// File: rtl/biriscv_div_arb.sv
// rtl/biriscv_div_arb.sv - shared two-pipe divide unit with arbitration, restoring divider and result tagging
// Optional early-out path guarded by BIRISCV_DIV_EARLY_OUT_EN.
module biriscv_div_arb #(
    parameter int RR_ARB = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req0_valid_i,
    input  logic [1:0]  req0_op_i,
    input  logic [31:0] req0_ra_i,
    input  logic [31:0] req0_rb_i,
    input  logic [4:0]  req0_rd_i,
    output logic        req0_accept_o,
    input  logic        req1_valid_i,
    input  logic [1:0]  req1_op_i,
    input  logic [31:0] req1_ra_i,
    input  logic [31:0] req1_rb_i,
    input  logic [4:0]  req1_rd_i,
    output logic        req1_accept_o,
    input  logic        flush_i,
    output logic        busy_o,
    output logic        complete_o,
    output logic        owner_o,
    output logic [4:0]  rd_o,
    output logic [31:0] result_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  count_q;
    logic        last_grant_q;
    logic [1:0]  op_q;
    logic [4:0]  rd_q;
    logic        owner_q;
    logic [31:0] quot_q, rem_q, divisor_q, result_q;
    logic        neg_quot_q, neg_rem_q;

    logic        grant1, accept;
    logic [1:0]  sel_op;
    logic [31:0] sel_ra, sel_rb, sel_ra_abs, sel_rb_abs;
    logic [4:0]  sel_rd;
    logic        sel_signed, sel_neg_quot, sel_neg_rem;

    logic [32:0] rem_shift, rem_sub;
    logic        step_ge;
    logic [31:0] rem_nx, quot_nx, quot_fix, rem_fix, calc_result;

    // Pipe 1 wins only when pipe 0 is absent, or in round-robin mode when pipe 0 had the last grant.
    always_comb begin
        if (RR_ARB != 0) begin
            grant1 = req1_valid_i & (~req0_valid_i | ~last_grant_q);
        end else begin
            grant1 = req1_valid_i & ~req0_valid_i;
        end
    end

    assign req0_accept_o = (state_q == S_IDLE) & ~flush_i & ~rst_i & req0_valid_i & ~grant1;
    assign req1_accept_o = (state_q == S_IDLE) & ~flush_i & ~rst_i & grant1;
    assign accept        = req0_accept_o | req1_accept_o;

    assign sel_op       = grant1 ? req1_op_i : req0_op_i;
    assign sel_ra       = grant1 ? req1_ra_i : req0_ra_i;
    assign sel_rb       = grant1 ? req1_rb_i : req0_rb_i;
    assign sel_rd       = grant1 ? req1_rd_i : req0_rd_i;
    assign sel_signed   = ~sel_op[0];
    assign sel_ra_abs   = (sel_signed & sel_ra[31]) ? -sel_ra : sel_ra;
    assign sel_rb_abs   = (sel_signed & sel_rb[31]) ? -sel_rb : sel_rb;
    assign sel_neg_quot = sel_signed & (sel_ra[31] ^ sel_rb[31]) & (sel_rb != 32'd0);
    assign sel_neg_rem  = sel_signed & sel_ra[31];

    // One restoring step; a zero divisor naturally yields all-ones quotient and remainder = |dividend|.
    assign rem_shift   = {rem_q, quot_q[31]};
    assign rem_sub     = rem_shift - {1'b0, divisor_q};
    assign step_ge     = rem_shift >= {1'b0, divisor_q};
    assign rem_nx      = step_ge ? rem_sub[31:0] : rem_shift[31:0];
    assign quot_nx     = {quot_q[30:0], step_ge};
    assign quot_fix    = neg_quot_q ? -quot_nx : quot_nx;
    assign rem_fix     = neg_rem_q ? -rem_nx : rem_nx;
    assign calc_result = op_q[1] ? rem_fix : quot_fix;

`ifdef BIRISCV_DIV_EARLY_OUT_EN
    logic        fast_path;
    logic [31:0] fast_result;

    assign fast_path   = (sel_rb == 32'd0) | (sel_ra_abs < sel_rb_abs);
    assign fast_result = sel_op[1] ? sel_ra : ((sel_rb == 32'd0) ? 32'hFFFF_FFFF : 32'd0);
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
`ifdef BIRISCV_DIV_EARLY_OUT_EN
                    state_d = fast_path ? S_DONE : S_CALC;
`else
                    state_d = S_CALC;
`endif
                end
            end
            S_CALC: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else if (count_q == 5'd0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            count_q      <= 5'd0;
            last_grant_q <= 1'b1;
            op_q         <= 2'd0;
            rd_q         <= 5'd0;
            owner_q      <= 1'b0;
            quot_q       <= 32'd0;
            rem_q        <= 32'd0;
            divisor_q    <= 32'd0;
            result_q     <= 32'd0;
            neg_quot_q   <= 1'b0;
            neg_rem_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q         <= sel_op;
                rd_q         <= sel_rd;
                owner_q      <= grant1;
                last_grant_q <= grant1;
                quot_q       <= sel_ra_abs;
                rem_q        <= 32'd0;
                divisor_q    <= sel_rb_abs;
                neg_quot_q   <= sel_neg_quot;
                neg_rem_q    <= sel_neg_rem;
                count_q      <= 5'd31;
`ifdef BIRISCV_DIV_EARLY_OUT_EN
                if (fast_path) begin
                    result_q <= fast_result;
                end
`endif
            end else if ((state_q == S_CALC) && !flush_i) begin
                rem_q  <= rem_nx;
                quot_q <= quot_nx;
                if (count_q == 5'd0) begin
                    result_q <= calc_result;
                end else begin
                    count_q <= count_q - 5'd1;
                end
            end
        end
    end

    assign busy_o     = (state_q != S_IDLE);
    assign complete_o = (state_q == S_DONE) & ~flush_i;
    assign owner_o    = owner_q;
    assign rd_o       = rd_q;
    assign result_o   = result_q;

endmodule
